// File: rtl/pong_pkg.sv
// Shared game constants, screen geometry and the sequencer state encoding
// for the Pong frame-rate game controller.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_POINT = 2'd2,
      ST_OVER  = 2'd3
   } state_e;

   localparam int FRAME_CYCLES_DEF = 833333;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int MISS_L   = 4;
   localparam int MISS_R   = SCREEN_W - 4;

   localparam int BALL_W       = 8;
   localparam int PADDLE_W     = 10;
   localparam int PADDLE_H     = 50;
   localparam int P1_X         = 20;
   localparam int P2_X         = 610;
   localparam int PADDLE_SPEED = 3;
   localparam int BALL_VX      = 3;
   localparam int POINT_FRAMES = 60;
   localparam int WIN_SCORE    = 7;

   localparam int CENTRE_X  = 316;
   localparam int CENTRE_Y  = 236;
   localparam int PADDLE_Y0 = 215;
   localparam int PADDLE_YMAX = SCREEN_H - PADDLE_H;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle between the game controller and the display/input side: paddle and
// serve buttons in, registered object coordinates, scores and state out.
interface pong_game_ctrl_if;

   // No valid/ready here: buttons are active-low levels sampled only in the
   // frame-tick cycle, and every output is a register that changes only in
   // the cycle after a tick, flagged by the one-cycle frame_tick pulse.
   logic       p1_up_n;
   logic       p1_dn_n;
   logic       p2_up_n;
   logic       p2_dn_n;
   logic       serve_n;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [9:0] p1_y;
   logic [9:0] p2_y;
   logic [3:0] score1;
   logic [3:0] score2;
   logic [1:0] state;
   logic       frame_tick;

   modport master (
      input  p1_up_n, p1_dn_n, p2_up_n, p2_dn_n, serve_n,
      output ball_x, ball_y, p1_y, p2_y, score1, score2, state, frame_tick
   );

   modport slave (
      output p1_up_n, p1_dn_n, p2_up_n, p2_dn_n, serve_n,
      input  ball_x, ball_y, p1_y, p2_y, score1, score2, state, frame_tick
   );

endinterface

// File: rtl/pong_paddle_mover.sv
// One paddle: moves by PADDLE_SPEED per frame tick from its up/down buttons,
// clamped to the visible screen; both or neither button holds position.
module pong_paddle_mover
   import pong_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       tick_i,
   input  logic       up_n_i,
   input  logic       dn_n_i,
   output logic [9:0] y_o
);

   logic [9:0] y_q;
   logic [9:0] y_d;

   always_comb begin
      y_d = y_q;
      if (!up_n_i && dn_n_i) begin
         y_d = (y_q < 10'(PADDLE_SPEED)) ? '0 : y_q - 10'(PADDLE_SPEED);
      end else if (up_n_i && !dn_n_i) begin
         y_d = (y_q > 10'(PADDLE_YMAX - PADDLE_SPEED)) ? 10'(PADDLE_YMAX)
                                                       : y_q + 10'(PADDLE_SPEED);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         y_q <= 10'(PADDLE_Y0);
      end else if (tick_i) begin
         y_q <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick generation, ball motion and collisions,
// serve/point/game-over sequencing and scoring, with two paddle movers.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
   input logic              CLOCK_50,
   input logic              rst_n,
   pong_game_ctrl_if.master bus
);

   localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

   localparam logic signed [10:0] S_BALL_W = 11'(BALL_W);
   localparam logic signed [10:0] S_PAD_H  = 11'(PADDLE_H);
   localparam logic signed [10:0] S_Y_BOT  = 11'(SCREEN_H - BALL_W);
   localparam logic signed [10:0] S_L_FACE = 11'(P1_X + PADDLE_W);
   localparam logic signed [10:0] S_L_BACK = 11'(P1_X);
   localparam logic signed [10:0] S_R_FACE = 11'(P2_X);
   localparam logic signed [10:0] S_R_BACK = 11'(P2_X + PADDLE_W);
   localparam logic signed [10:0] S_MISS_L = 11'(MISS_L);
   localparam logic signed [10:0] S_MISS_R = 11'(MISS_R);
   localparam logic signed [10:0] S_VX     = 11'(BALL_VX);
   localparam logic signed [10:0] S_VY_UP  = -11'sd1;

   logic [CW-1:0]      cnt_q;
   logic               tick;
   logic               tick_q;
   state_e             state_q;
   logic [9:0]         ball_x_q, ball_y_q;
   logic signed [10:0] vx_q, vy_q;
   logic [3:0]         score1_q, score2_q;
   logic               server_q;     // 0: P1 serves, 1: P2 serves
   logic [6:0]         pt_cnt_q;
   logic [9:0]         p1_y, p2_y;

   logic signed [10:0] nx, ny, p1s, p2s;
   logic [9:0]         ball_y_d;
   logic signed [10:0] vy_d;
   logic               hit_l, hit_r, miss_l, miss_r, win_d;

   assign tick = (cnt_q == CW'(FRAME_CYCLES - 1));

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= tick ? '0 : cnt_q + CW'(1);
         tick_q <= tick;
      end
   end

   pong_paddle_mover u_p1 (
      .clk_i(CLOCK_50), .rst_n_i(rst_n), .tick_i(tick),
      .up_n_i(bus.p1_up_n), .dn_n_i(bus.p1_dn_n), .y_o(p1_y)
   );

   pong_paddle_mover u_p2 (
      .clk_i(CLOCK_50), .rst_n_i(rst_n), .tick_i(tick),
      .up_n_i(bus.p2_up_n), .dn_n_i(bus.p2_dn_n), .y_o(p2_y)
   );

   // Collisions use the paddle registers before this tick's paddle move.
   assign p1s = $signed({1'b0, p1_y});
   assign p2s = $signed({1'b0, p2_y});

   always_comb begin
      nx       = $signed({1'b0, ball_x_q}) + vx_q;
      ny       = $signed({1'b0, ball_y_q}) + vy_q;
      ball_y_d = ny[9:0];
      vy_d     = vy_q;
      if (ny < 0) begin
         ball_y_d = '0;
         vy_d     = -vy_q;
      end else if (ny > S_Y_BOT) begin
         ball_y_d = 10'(SCREEN_H - BALL_W);
         vy_d     = -vy_q;
      end
      hit_l  = (vx_q < 0) && (nx <= S_L_FACE) && (nx + S_BALL_W > S_L_BACK) &&
               (ny < p1s + S_PAD_H) && (ny + S_BALL_W > p1s);
      hit_r  = (vx_q > 0) && (nx + S_BALL_W >= S_R_FACE) && (nx < S_R_BACK) &&
               (ny < p2s + S_PAD_H) && (ny + S_BALL_W > p2s);
      miss_l = (nx < S_MISS_L);
      miss_r = (nx + S_BALL_W > S_MISS_R);
      win_d  = miss_l ? (score2_q == 4'(WIN_SCORE - 1)) : (score1_q == 4'(WIN_SCORE - 1));
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ball_x_q <= 10'(CENTRE_X);
         ball_y_q <= 10'(CENTRE_Y);
         vx_q     <= '0;
         vy_q     <= '0;
         score1_q <= '0;
         score2_q <= '0;
         server_q <= 1'b0;
         pt_cnt_q <= '0;
      end else if (tick) begin
         unique case (state_q)
            ST_IDLE: begin
               ball_x_q <= 10'(CENTRE_X);
               ball_y_q <= 10'(CENTRE_Y);
               vx_q     <= '0;
               vy_q     <= '0;
               if (!bus.serve_n) begin
                  state_q <= ST_PLAY;
                  vx_q    <= server_q ? -S_VX : S_VX;
                  vy_q    <= S_VY_UP;
               end
            end
            ST_PLAY: begin
               if (hit_l || hit_r) begin
                  ball_x_q <= hit_l ? 10'(P1_X + PADDLE_W) : 10'(P2_X - BALL_W);
                  vx_q     <= -vx_q;
                  ball_y_q <= ball_y_d;
                  vy_q     <= vy_d;
               end else if (miss_l || miss_r) begin
                  // Ball freezes where it was; the player who lost serves next.
                  vx_q     <= '0;
                  vy_q     <= '0;
                  pt_cnt_q <= 7'(POINT_FRAMES);
                  server_q <= miss_r;
                  if (miss_l) score2_q <= score2_q + 4'd1;
                  else        score1_q <= score1_q + 4'd1;
                  if (win_d) begin
                     state_q  <= ST_OVER;
                     ball_x_q <= 10'(CENTRE_X);
                     ball_y_q <= 10'(CENTRE_Y);
                  end else begin
                     state_q <= ST_POINT;
                  end
               end else begin
                  ball_x_q <= nx[9:0];
                  ball_y_q <= ball_y_d;
                  vy_q     <= vy_d;
               end
            end
            ST_POINT: begin
               if (pt_cnt_q <= 7'd1) begin
                  pt_cnt_q <= '0;
                  state_q  <= ST_IDLE;
                  ball_x_q <= 10'(CENTRE_X);
                  ball_y_q <= 10'(CENTRE_Y);
               end else begin
                  pt_cnt_q <= pt_cnt_q - 7'd1;
               end
            end
            ST_OVER: begin
               if (!bus.serve_n) begin
                  score1_q <= '0;
                  score2_q <= '0;
                  server_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.ball_x     = ball_x_q;
   assign bus.ball_y     = ball_y_q;
   assign bus.p1_y       = p1_y;
   assign bus.p2_y       = p2_y;
   assign bus.score1     = score1_q;
   assign bus.score2     = score2_q;
   assign bus.state      = state_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a short frame period: paddles,
// serve, wall and paddle bounces, both miss sides, point pause, game over, reset.
module tb_pong_game_ctrl;
   import pong_pkg::*;

   localparam int F = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   pong_game_ctrl_if bus ();

   pong_game_ctrl #(.FRAME_CYCLES(F)) dut (
      .CLOCK_50(clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic next_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.frame_tick !== 1'b1 && n < 3 * F);
      if (bus.frame_tick !== 1'b1) check_eq("frame_timeout", 0, 1);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) next_frame();
   endtask

   task automatic check_ball(input string tag, input int x, input int y);
      check_eq({tag, "_x"}, int'(bus.ball_x), x);
      check_eq({tag, "_y"}, int'(bus.ball_y), y);
   endtask

   task automatic check_reset_values(input string tag);
      check_ball(tag, 316, 236);
      check_eq({tag, "_state"}, int'(bus.state), 0);
      check_eq({tag, "_p1"}, int'(bus.p1_y), 215);
      check_eq({tag, "_p2"}, int'(bus.p2_y), 215);
      check_eq({tag, "_s1"}, int'(bus.score1), 0);
      check_eq({tag, "_s2"}, int'(bus.score2), 0);
      check_eq({tag, "_tick"}, int'(bus.frame_tick), 0);
   endtask

   // Server P2, p1 at 145, p2 at 0: P1 returns at x=30 and P2 misses.
   task automatic rally_p2_serve(input int r);
      bus.serve_n = 1'b0;
      next_frame();
      bus.serve_n = 1'b1;
      frames(96);
      check_ball($sformatf("r%0d_lhit", r), 30, 140);
      frames(200);
      check_eq($sformatf("r%0d_s1", r), int'(bus.score1), r);
      if (r < 7) begin
         check_eq($sformatf("r%0d_st", r), int'(bus.state), 2);
         frames(60);
         check_eq($sformatf("r%0d_idle", r), int'(bus.state), 0);
      end else begin
         check_eq("over_st", int'(bus.state), 3);
         check_ball("over_ball", 316, 236);
      end
   endtask

   initial begin
      int n;
      bus.p1_up_n = 1'b1;
      bus.p1_dn_n = 1'b1;
      bus.p2_up_n = 1'b1;
      bus.p2_dn_n = 1'b1;
      bus.serve_n = 1'b1;

      repeat (3) @(negedge clk);
      check_reset_values("rst");
      rst_n = 1'b1;

      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.frame_tick !== 1'b1 && n < 3 * F);
      check_eq("first_tick_latency", n, F);
      @(negedge clk);
      check_eq("tick_width", int'(bus.frame_tick), 0);
      frames(2);
      check_ball("idle3", 316, 236);
      check_eq("idle3_p1", int'(bus.p1_y), 215);
      check_eq("idle3_p2", int'(bus.p2_y), 215);
      check_eq("idle3_state", int'(bus.state), 0);

      // p1 down for 100 frames, p2 up for the first 25
      bus.p1_dn_n = 1'b0;
      bus.p2_up_n = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         next_frame();
         if (k == 1)  check_eq("p1_dn_1", int'(bus.p1_y), 218);
         if (k == 25) bus.p2_up_n = 1'b1;
         if (k == 71) check_eq("p1_dn_71", int'(bus.p1_y), 428);
         if (k == 72) check_eq("p1_dn_clamp", int'(bus.p1_y), 430);
      end
      check_eq("p1_dn_100", int'(bus.p1_y), 430);
      check_eq("p2_up_25", int'(bus.p2_y), 140);
      bus.p1_up_n = 1'b0;
      next_frame();
      check_eq("p1_both", int'(bus.p1_y), 430);
      bus.p1_up_n = 1'b1;
      bus.p1_dn_n = 1'b1;

      // Serve by P1: right-paddle hit, top wall, then P1 misses on the left
      bus.serve_n = 1'b0;
      next_frame();
      check_eq("serve_state", int'(bus.state), 1);
      check_ball("serve_pos", 316, 236);
      bus.serve_n = 1'b1;
      for (int t = 1; t <= 96; t++) begin
         next_frame();
         if (t == 1) check_ball("play_t1", 319, 235);
      end
      check_ball("p2_hit", 602, 140);
      check_eq("p2_hit_state", int'(bus.state), 1);
      check_eq("p2_hit_s1", int'(bus.score1), 0);
      for (int s = 1; s <= 199; s++) begin
         next_frame();
         if (s == 1)   check_ball("after_hit", 599, 139);
         if (s == 140) check_ball("top_reach", 182, 0);
         if (s == 141) check_ball("top_clamp", 179, 0);
         if (s == 142) check_ball("top_bounce", 176, 1);
      end
      check_ball("pre_miss_l", 5, 58);
      next_frame();
      check_eq("miss_l_state", int'(bus.state), 2);
      check_eq("miss_l_s2", int'(bus.score2), 1);
      check_eq("miss_l_s1", int'(bus.score1), 0);
      check_ball("miss_l_frozen", 5, 58);

      // Point pause; paddles keep moving
      bus.p1_up_n = 1'b0;
      bus.p2_up_n = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         next_frame();
         if (k == 46) check_eq("p2_up_46", int'(bus.p2_y), 2);
         if (k == 47) check_eq("p2_up_clamp", int'(bus.p2_y), 0);
         if (k == 59) check_eq("point_59", int'(bus.state), 2);
      end
      check_eq("point_end", int'(bus.state), 0);
      check_ball("point_centre", 316, 236);
      check_eq("p1_in_point", int'(bus.p1_y), 250);
      bus.p2_up_n = 1'b1;
      frames(35);
      bus.p1_up_n = 1'b1;
      check_eq("p1_pos", int'(bus.p1_y), 145);
      check_eq("p2_pos", int'(bus.p2_y), 0);

      // Serve by P1 again: P2 paddle at 0 misses, point to P1
      bus.serve_n = 1'b0;
      next_frame();
      bus.serve_n = 1'b1;
      frames(104);
      check_ball("pre_miss_r", 628, 132);
      next_frame();
      check_eq("miss_r_state", int'(bus.state), 2);
      check_eq("miss_r_s1", int'(bus.score1), 1);
      check_eq("miss_r_s2", int'(bus.score2), 1);
      frames(60);
      check_eq("miss_r_idle", int'(bus.state), 0);

      // P2 now serves leftward
      bus.serve_n = 1'b0;
      next_frame();
      bus.serve_n = 1'b1;
      next_frame();
      check_ball("p2_serve_t1", 313, 235);
      frames(95);
      check_ball("p1_hit", 30, 140);
      next_frame();
      check_ball("p1_hit_after", 33, 139);
      frames(198);
      check_ball("pre_miss_r2", 627, 58);
      next_frame();
      check_eq("miss_r2_s1", int'(bus.score1), 2);
      frames(60);

      for (int r = 3; r <= 7; r++) rally_p2_serve(r);
      check_eq("over_s2", int'(bus.score2), 1);
      next_frame();
      check_eq("over_hold", int'(bus.state), 3);

      // Restart clears scores; serve held through restart serves next tick
      bus.serve_n = 1'b0;
      next_frame();
      check_eq("restart_state", int'(bus.state), 0);
      check_eq("restart_s1", int'(bus.score1), 0);
      check_eq("restart_s2", int'(bus.score2), 0);
      next_frame();
      check_eq("held_serve", int'(bus.state), 1);
      bus.serve_n = 1'b1;
      next_frame();
      check_ball("restart_p1_serve", 319, 235);

      rst_n = 1'b0;
      @(negedge clk);
      check_reset_values("mid_rst");
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
